wb_sequencer: RTL and testbench

Multi-cycle writeback sequencer for the RISC datapath. It accepts one decoded instruction at a time from execute and runs any data-memory access with a ready/ack handshake and timeout. It then drives the D-bus source select, the captured function, memory and N^V values, and a one-cycle register-file write strobe. It sits between execute, the data-memory port and the D-bus source mux.

---
 rtl/wb_sequencer.sv | 120 ++++++++++++
 tb/tb_wb_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_sequencer.sv
// Writeback sequencer: takes one decoded instruction and runs its data-memory access
// with an ack timeout. It then drives the D-bus source select, the captured values and a one-cycle register-file write.
module wb_sequencer #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_md,
  input  logic              in_rw,
  input  logic [4:0]        in_da,
  input  logic              in_mw,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_func,
  input  logic              in_nxorv,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        md_sel,
  output logic [DATA_W-1:0] func_out,
  output logic [DATA_W-1:0] data_out,
  output logic              nxorv,
  output logic              rf_we,
  output logic [4:0]        rf_da,
  output logic              bus_err,
  output logic              illegal
);

  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rw_q;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rw_q      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      md_sel    <= 2'd0;
      func_out  <= '0;
      data_out  <= '0;
      nxorv     <= 1'b0;
      rf_we     <= 1'b0;
      rf_da     <= 5'd0;
      bus_err   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Illegal instructions are dropped without touching any captured output
            if (in_md == 2'd3 || (in_mw && in_md == 2'd1)) begin
              illegal <= 1'b1;
            end else begin
              md_sel    <= in_md;
              rw_q      <= in_rw;
              rf_da     <= in_da;
              mem_we    <= in_mw;
              mem_addr  <= in_addr;
              mem_wdata <= in_wdata;
              func_out  <= in_func;
              nxorv     <= in_nxorv;
              cnt       <= '0;
              if (in_md == 2'd1 || in_mw) begin
                state   <= MEM;
                mem_req <= 1'b1;
              end else if (in_rw) begin
                state <= WB;
                rf_we <= 1'b1;
              end
            end
          end
        end
        MEM: begin
          // An ack in the final allowed cycle still wins over the timeout
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) data_out <= mem_rdata;
            if (rw_q) begin
              state <= WB;
              rf_we <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (cnt == TO_LAST) begin
            bus_err <= 1'b1;
            mem_req <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WB: begin
          rf_we <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer; inputs change and outputs are sampled 1ns after each rising edge.
module tb_wb_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [1:0]  in_md;
  logic        in_rw, in_mw, in_nxorv;
  logic [4:0]  in_da;
  logic [31:0] in_addr, in_wdata, in_func;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  md_sel;
  logic [31:0] func_out, data_out;
  logic        nxorv, rf_we, bus_err, illegal;
  logic [4:0]  rf_da;

  int checks = 0;
  int passes = 0;

  wb_sequencer #(.DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_md(in_md), .in_rw(in_rw), .in_da(in_da), .in_mw(in_mw),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_func(in_func), .in_nxorv(in_nxorv),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .md_sel(md_sel), .func_out(func_out),
    .data_out(data_out), .nxorv(nxorv), .rf_we(rf_we), .rf_da(rf_da),
    .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    else
      passes++;
  endtask

  // Offers one instruction for a single edge; returns in the cycle after the accepting edge
  task automatic applyStimulus(input logic [1:0] md, input logic rw, input logic [4:0] da,
                               input logic mw, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] func, input logic nv);
    in_valid = 1'b1;
    in_md = md; in_rw = rw; in_da = da; in_mw = mw;
    in_addr = addr; in_wdata = wdata; in_func = func; in_nxorv = nv;
    step();
    in_valid = 1'b0;
  endtask

  int  n_req;
  logic saw_we;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_md = 2'd0; in_rw = 1'b0; in_da = 5'd0; in_mw = 1'b0;
    in_addr = '0; in_wdata = '0; in_func = '0; in_nxorv = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    step();
    step();
    checkOutput("rst_ready", in_ready, 1);
    checkOutput("rst_outs", {mem_req, mem_we, md_sel, nxorv, rf_we, bus_err, illegal, rf_da}, 0);
    checkOutput("rst_data", mem_addr | mem_wdata | func_out | data_out, 0);
    reset = 1'b0;
    step();

    // ALU write, then a back-to-back one two cycles later
    applyStimulus(2'd0, 1'b1, 5'd5, 1'b0, 32'h0, 32'h0, 32'h1234, 1'b0);
    checkOutput("alu_rf_we", rf_we, 1);
    checkOutput("alu_rf_da", rf_da, 5);
    checkOutput("alu_md_sel", md_sel, 0);
    checkOutput("alu_func", func_out, 32'h1234);
    checkOutput("alu_busy", in_ready, 0);
    checkOutput("alu_no_req", mem_req, 0);
    step();
    checkOutput("alu_we_drop", rf_we, 0);
    checkOutput("alu_ready", in_ready, 1);
    applyStimulus(2'd0, 1'b1, 5'd6, 1'b0, 32'h0, 32'h0, 32'h5678, 1'b0);
    checkOutput("b2b_rf_we", rf_we, 1);
    checkOutput("b2b_rf_da", rf_da, 6);
    step();

    // Load with three wait cycles
    applyStimulus(2'd1, 1'b1, 5'd7, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ld_req", mem_req, 1);
      checkOutput("ld_we", mem_we, 0);
      checkOutput("ld_addr", mem_addr, 32'h40);
      checkOutput("ld_no_we", rf_we, 0);
      if (i == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
      end
      step();
    end
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    checkOutput("ld_req_drop", mem_req, 0);
    checkOutput("ld_rf_we", rf_we, 1);
    checkOutput("ld_data", data_out, 32'hDEADBEEF);
    checkOutput("ld_md_sel", md_sel, 1);
    checkOutput("ld_rf_da", rf_da, 7);
    step();
    checkOutput("ld_ready", in_ready, 1);
    checkOutput("ld_we_drop", rf_we, 0);

    // SLT writes N^V
    applyStimulus(2'd2, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    checkOutput("slt_rf_we", rf_we, 1);
    checkOutput("slt_md_sel", md_sel, 2);
    checkOutput("slt_nxorv", nxorv, 1);
    checkOutput("slt_no_req", mem_req, 0);
    step();

    // Store without write-back, ack after one wait cycle
    applyStimulus(2'd0, 1'b0, 5'd0, 1'b1, 32'h80, 32'hA5A5A5A5, 32'h99, 1'b0);
    checkOutput("st_req", mem_req, 1);
    checkOutput("st_we", mem_we, 1);
    checkOutput("st_addr", mem_addr, 32'h80);
    checkOutput("st_wdata", mem_wdata, 32'hA5A5A5A5);
    step();
    checkOutput("st_req_hold", mem_req, 1);
    checkOutput("st_we_hold", mem_we, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkOutput("st_req_drop", mem_req, 0);
    checkOutput("st_no_rf_we", rf_we, 0);
    checkOutput("st_ready", in_ready, 1);
    checkOutput("st_data_kept", data_out, 32'hDEADBEEF);

    // Store that never gets an ack
    applyStimulus(2'd0, 1'b0, 5'd0, 1'b1, 32'h84, 32'h11112222, 32'h0, 1'b0);
    n_req = 0;
    saw_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) n_req++;
      if (rf_we) saw_we = 1'b1;
      if (i == 14) checkOutput("to_err_late", bus_err, 0);
      if (i == 15) checkOutput("to_err_set", bus_err, 1);
      step();
    end
    checkOutput("to_req_cycles", n_req, 15);
    checkOutput("to_no_rf_we", saw_we, 0);
    checkOutput("to_ready", in_ready, 1);
    mem_ack = 1'b1;
    mem_rdata = 32'h0BAD0BAD;
    step();
    mem_ack = 1'b0;
    checkOutput("stray_ack_data", data_out, 32'hDEADBEEF);
    checkOutput("stray_ack_we", rf_we, 0);

    // Next instruction still accepted; bus_err is sticky
    applyStimulus(2'd0, 1'b1, 5'd10, 1'b0, 32'h0, 32'h0, 32'hCAFE, 1'b0);
    checkOutput("post_to_rf_we", rf_we, 1);
    checkOutput("post_to_da", rf_da, 10);
    checkOutput("bus_err_sticky", bus_err, 1);
    in_valid = 1'b1;
    in_md = 2'd0; in_rw = 1'b1; in_da = 5'd12; in_mw = 1'b0;
    step();
    in_valid = 1'b0;
    checkOutput("busy_ignored_we", rf_we, 0);
    checkOutput("busy_ignored_da", rf_da, 10);

    // Illegal encodings
    applyStimulus(2'd3, 1'b1, 5'd9, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("ill3_pulse", illegal, 1);
    checkOutput("ill3_ready", in_ready, 1);
    checkOutput("ill3_no_we", rf_we, 0);
    checkOutput("ill3_da_kept", rf_da, 10);
    step();
    checkOutput("ill3_drop", illegal, 0);
    applyStimulus(2'd1, 1'b1, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("illmw_pulse", illegal, 1);
    checkOutput("illmw_no_req", mem_req, 0);
    step();
    checkOutput("illmw_drop", illegal, 0);
    checkOutput("illmw_no_req2", mem_req, 0);

    // Reset during a memory wait
    applyStimulus(2'd1, 1'b1, 5'd4, 1'b0, 32'h44, 32'h0, 32'h77, 1'b0);
    step();
    checkOutput("mid_req", mem_req, 1);
    reset = 1'b1;
    step();
    checkOutput("mid_rst_req", mem_req, 0);
    checkOutput("mid_rst_ready", in_ready, 1);
    checkOutput("mid_rst_outs", {mem_we, md_sel, nxorv, rf_we, bus_err, illegal, rf_da}, 0);
    checkOutput("mid_rst_data", mem_addr | func_out | data_out, 0);
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    checkOutput("late_ack_data", data_out, 0);
    checkOutput("late_ack_we", rf_we, 0);
    step();
    checkOutput("late_ack_idle", {mem_req, rf_we, in_ready}, 1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
